spr_resp: RTL

Request/response front end for a single-port synchronous RAM. It accepts write and read requests over a valid/ready channel and stores data in an internal `2^ADD_W x DATA_W` array. Read data returns on a separate valid/ready response channel that supports backpressure. The block is the responder side of the memory-access interface, and the sequential initiators in the design connect to it.

---
 rtl/spr_resp.sv | 114 +++++++++++
 1 files changed

// File: rtl/spr_resp.sv
// Valid/ready request/response front end for a single-port 2^ADD_W x DATA_W RAM.
// Define SPR_RESP_CLEAR_EN to zero the whole array after every reset before accepting requests.
module spr_resp #(
  parameter int DATA_W = 8,
  parameter int ADD_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADD_W-1:0]  req_add,
  input  logic [DATA_W-1:0] req_din,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_dout
);

  localparam int DEPTH = 1 << ADD_W;

`ifdef SPR_RESP_CLEAR_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd1, CLEAR = 2'd2} state_t;
  localparam state_t RESET_STATE = CLEAR;
  logic [ADD_W-1:0] clr_cnt;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd1} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t            state;
  state_t            next_state;
  logic              rd_en;
  logic              mem_we;
  logic [ADD_W-1:0]  mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  assign req_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_STATE;
    end else begin
      state <= next_state;
    end
  end

  // The single write port is shared between request writes and the clear sweep.
  always_comb begin
    next_state = state;
    rd_en      = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = req_add;
    mem_wdata  = req_din;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          if (req_we) begin
            mem_we = 1'b1;
          end else begin
            rd_en      = 1'b1;
            next_state = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          next_state = IDLE;
        end
      end
`ifdef SPR_RESP_CLEAR_EN
      CLEAR: begin
        mem_we    = !rst;
        mem_addr  = clr_cnt;
        mem_wdata = '0;
        if (clr_cnt == ADD_W'(DEPTH - 1)) begin
          next_state = IDLE;
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

`ifdef SPR_RESP_CLEAR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + ADD_W'(1);
    end
  end
`endif

  // Storage has no reset so contents survive rst when the sweep is disabled.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_dout  <= '0;
    end else if (rd_en) begin
      rsp_valid <= 1'b1;
      rsp_dout  <= mem[req_add];
    end else if ((state == RESP) && rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
